// File: rtl/music_pkg.sv
// Shared types and constants for the music player: FSM state encoding,
// sheet field widths, duration codes and the rest marker.
package music_pkg;

  localparam int IDX_W  = 10;
  localparam int NOTE_W = 20;
  localparam int DUR_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } player_state_t;

  // Durations are in eighth-note ticks; ONE/TWO/FOUR count quarter-note beats.
  localparam logic [DUR_W-1:0] QUARTER = 5'd2;
  localparam logic [DUR_W-1:0] HALF    = 5'd4;
  localparam logic [DUR_W-1:0] ONE     = 5'd2;
  localparam logic [DUR_W-1:0] TWO     = 5'd4;
  localparam logic [DUR_W-1:0] FOUR    = 5'd8;

  localparam logic [NOTE_W-1:0] SP = 20'd1;

  // A zero-length entry still plays for one tick so the sequencer always advances.
  function automatic logic [DUR_W-1:0] dur_floor(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/music_player_tone_gen.sv
// Half-period counter and toggle flop producing the speaker square wave.
// Output is silent when disabled or when the half-period marks a rest (<= 1).
module tone_gen
  import music_pkg::*;
#(
  parameter int HP_W = NOTE_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clear,
  input  logic [HP_W-1:0] half_period,
  output logic            wave
);

  logic [HP_W-1:0] cnt;
  logic            wave_q;
  logic            active;

  assign active = en && (half_period > HP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      wave_q <= 1'b0;
    end else if (clear) begin
      cnt    <= '0;
      wave_q <= 1'b0;
    end else if (active) begin
      if (cnt == half_period - HP_W'(1)) begin
        cnt    <= '0;
        wave_q <= ~wave_q;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  assign wave = active & wave_q;

endmodule

// File: rtl/music_player.sv
// Note sequencer: steps the sheet index, plays each note for its duration,
// then a silent gap. Optional macro MUSIC_PLAYER_LOOP_EN repeats the tune until stop.
module music_player
  import music_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000,
  parameter int LAST_INDEX  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [IDX_W-1:0]  number,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output player_state_t     dbg_state
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  player_state_t     state, state_d;
  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic [TICK_W-1:0] tick_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              tick_last, gap_last, is_last;

  assign tick_last = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign gap_last  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign is_last   = (number == IDX_W'(LAST_INDEX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = PLAY;
      PLAY: if (tick_last && dur_q == DUR_W'(1)) state_d = GAP;
      GAP: begin
        if (gap_last) begin
          if (is_last) begin
`ifdef MUSIC_PLAYER_LOOP_EN
            state_d = LOAD;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // stop overrides start and the end-of-tune transition
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number   <= '0;
      note_q   <= '0;
      dur_q    <= '0;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == GAP) && gap_last && is_last && !stop;
      case (state)
        IDLE: begin
          number   <= '0;
          tick_cnt <= '0;
          gap_cnt  <= '0;
        end
        LOAD: begin
          note_q   <= note;
          dur_q    <= dur_floor(duration);
          tick_cnt <= '0;
          gap_cnt  <= '0;
        end
        PLAY: begin
          if (tick_last) begin
            tick_cnt <= '0;
            dur_q    <= dur_q - DUR_W'(1);
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            gap_cnt <= '0;
            number  <= is_last ? '0 : number + IDX_W'(1);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: ;
      endcase
      if (stop) number <= '0;
    end
  end

  tone_gen #(.HP_W(NOTE_W)) u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state == PLAY),
    .clear       (state == LOAD),
    .half_period (note_q),
    .wave        (speaker)
  );

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
